// File: rtl/cva6_dmr_resync_ctrl.sv
// Resynchronisation sequencer for a CVA6 lockstep group behind the HMR unit.
// On a hardware or software trigger it halts every hart through debug request and
// waits until all harts sit at the rendezvous point. It then pulses core setback and
// reports completion to the HMR unit. A rendezvous that never completes parks the
// block in ERROR with a sticky timeout flag until software clears it.
// Handshake: triggers are sampled on every rising clock edge. A trigger seen while a
// sequence is in flight is folded into one pending re-run. Triggers seen in ERROR are
// dropped. All outputs are Moore outputs decoded from the registered state only.
module cva6_dmr_resync_ctrl #(
   parameter int unsigned NumHarts      = 2,
   parameter int unsigned SetbackCycles = 4,
   parameter int unsigned TimeoutCycles = 1024,
   parameter int unsigned CntWidth      = $clog2(TimeoutCycles + SetbackCycles + 1)
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                hw_resynch_req_i,
   input  logic                sw_resynch_req_i,
   input  logic [NumHarts-1:0] harts_sync_req_i,
   input  logic                clear_timeout_i,
   output logic [NumHarts-1:0] debug_req_o,
   output logic [NumHarts-1:0] core_setback_o,
   output logic                cores_synch_o,
   output logic                busy_o,
   output logic                timeout_o
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_SETBACK = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_e;

   localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [CntWidth-1:0] SetbackLast = CntWidth'(SetbackCycles - 1);

   state_e              state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic                pending_q, pending_d;

   logic                req_in;
   logic                all_sync;
   logic [CntWidth-1:0] cnt_inc;

   assign req_in   = hw_resynch_req_i | sw_resynch_req_i;
   assign all_sync = &harts_sync_req_i;
   // Saturating increment so the counter can never wrap inside a state.
   assign cnt_inc  = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);

   // State, shared counter and pending flag registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   // Next-state, counter and pending-flag logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (req_in || pending_q) begin
               state_d   = S_REQ;
               pending_d = 1'b0;
            end
         end
         S_REQ: begin
            cnt_d     = '0;
            pending_d = pending_q | req_in;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            pending_d = pending_q | req_in;
            cnt_d     = cnt_inc;
            // A rendezvous in the last allowed cycle still counts as success.
            if (all_sync) begin
               state_d = S_SETBACK;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d = S_ERROR;
            end
         end
         S_SETBACK: begin
            pending_d = pending_q | req_in;
            cnt_d     = cnt_inc;
            if (cnt_q == SetbackLast) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end
         end
         S_DONE: begin
            cnt_d = '0;
            // A level hw request still high here is seen as one more trigger.
            if (pending_q || req_in) begin
               state_d   = S_REQ;
               pending_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ERROR: begin
            cnt_d     = '0;
            pending_d = 1'b0;
            if (clear_timeout_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            pending_d = 1'b0;
         end
      endcase
   end

   // Moore output decode from the registered state.
   always_comb begin
      debug_req_o    = '0;
      core_setback_o = '0;
      cores_synch_o  = 1'b0;
      busy_o         = 1'b0;
      timeout_o      = 1'b0;
      case (state_q)
         S_REQ: begin
            debug_req_o = {NumHarts{1'b1}};
            busy_o      = 1'b1;
         end
         S_WAIT: begin
            busy_o = 1'b1;
         end
         S_SETBACK: begin
            core_setback_o = {NumHarts{1'b1}};
            busy_o         = 1'b1;
         end
         S_DONE: begin
            cores_synch_o = 1'b1;
            busy_o        = 1'b1;
         end
         S_ERROR: begin
            timeout_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_cva6_dmr_resync_ctrl.sv
// Directed bench for the lockstep resync sequencer (NumHarts=2, SetbackCycles=4,
// TimeoutCycles=16). Cycle c means the clock period after the c-th rising edge that
// follows the trigger edge. Inputs driven during cycle c are sampled at the end of
// that cycle. Outputs are observed 1 ns after each rising edge.
module tb_cva6_dmr_resync_ctrl;

   logic       clk;
   logic       rstn;
   logic       hw_req;
   logic       sw_req;
   logic [1:0] sync_req;
   logic       clr_to;
   logic [1:0] debug_req;
   logic [1:0] setback;
   logic       synch;
   logic       busy;
   logic       timeout;

   int n_cmp;
   int n_err;

   cva6_dmr_resync_ctrl #(
      .NumHarts      (2),
      .SetbackCycles (4),
      .TimeoutCycles (16)
   ) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .hw_resynch_req_i (hw_req),
      .sw_resynch_req_i (sw_req),
      .harts_sync_req_i (sync_req),
      .clear_timeout_i  (clr_to),
      .debug_req_o      (debug_req),
      .core_setback_o   (setback),
      .cores_synch_o    (synch),
      .busy_o           (busy),
      .timeout_o        (timeout)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tn, input int c, input logic [1:0] e_dbg,
                          input logic [1:0] e_sb, input logic e_syn, input logic e_busy,
                          input logic e_to);
      chk($sformatf("%s c%0d debug_req", tn, c), 32'(debug_req), 32'(e_dbg));
      chk($sformatf("%s c%0d setback", tn, c), 32'(setback), 32'(e_sb));
      chk($sformatf("%s c%0d cores_synch", tn, c), 32'(synch), 32'(e_syn));
      chk($sformatf("%s c%0d busy", tn, c), 32'(busy), 32'(e_busy));
      chk($sformatf("%s c%0d timeout", tn, c), 32'(timeout), 32'(e_to));
   endtask

   // Single software pulse; returns 1 ns after the trigger edge (start of cycle 1).
   task automatic sw_trigger();
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
   endtask

   task automatic idle_gap(input int n);
      hw_req   = 1'b0;
      sw_req   = 1'b0;
      clr_to   = 1'b0;
      sync_req = 2'b00;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rstn     = 1'b0;
      hw_req   = 1'b0;
      sw_req   = 1'b0;
      sync_req = 2'b00;
      clr_to   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      idle_gap(2);
      chk_all("idle", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

      // 1: harts already synced -> REQ@1, WAIT@2, SETBACK@3..6, DONE@7, IDLE@8.
      sync_req = 2'b11;
      sw_trigger();
      for (int c = 1; c <= 9; c++) begin
         chk_all("t1", c, (c == 1) ? 2'b11 : 2'b00, (c >= 3 && c <= 6) ? 2'b11 : 2'b00,
                 c == 7, c >= 1 && c <= 7, 1'b0);
         step();
      end
      idle_gap(3);

      // 2: partial sync 01 from cycle 2, full sync in cycle 10.
      sw_trigger();
      for (int c = 1; c <= 16; c++) begin
         sync_req = (c >= 10) ? 2'b11 : ((c >= 2) ? 2'b01 : 2'b00);
         chk_all("t2", c, (c == 1) ? 2'b11 : 2'b00, (c >= 11 && c <= 14) ? 2'b11 : 2'b00,
                 c == 15, c >= 1 && c <= 15, 1'b0);
         step();
      end
      idle_gap(3);

      // 3: no rendezvous -> ERROR@18; sw pulses in ERROR dropped; clear@30 -> IDLE@31.
      sw_trigger();
      for (int c = 1; c <= 34; c++) begin
         sw_req = (c == 20 || c == 22);
         clr_to = (c == 30);
         chk_all("t3", c, (c == 1) ? 2'b11 : 2'b00, 2'b00, 1'b0, c >= 1 && c <= 17,
                 c >= 18 && c <= 30);
         step();
      end
      idle_gap(3);

      // 4: full sync first seen in the timeout cycle 17 -> SETBACK@18..21, DONE@22.
      sw_trigger();
      for (int c = 1; c <= 23; c++) begin
         sync_req = (c >= 17) ? 2'b11 : 2'b01;
         chk_all("t4", c, (c == 1) ? 2'b11 : 2'b00, (c >= 18 && c <= 21) ? 2'b11 : 2'b00,
                 c == 22, c >= 1 && c <= 22, 1'b0);
         step();
      end
      idle_gap(3);

      // 5: hw pulse in WAIT and two sw pulses in SETBACK collapse to one re-run:
      //    SETBACK@6..9, DONE@10, REQ@11, WAIT@12, SETBACK@13..16, DONE@17, IDLE@18.
      sw_trigger();
      for (int c = 1; c <= 20; c++) begin
         sync_req = (c >= 5) ? 2'b11 : 2'b00;
         hw_req   = (c == 3);
         sw_req   = (c == 7 || c == 8);
         chk_all("t5", c, (c == 1 || c == 11) ? 2'b11 : 2'b00,
                 ((c >= 6 && c <= 9) || (c >= 13 && c <= 16)) ? 2'b11 : 2'b00,
                 c == 10 || c == 17, c >= 1 && c <= 17, 1'b0);
         step();
      end
      idle_gap(3);

      // 6: reset asserted mid-SETBACK drops outputs at once; nothing completes later.
      sync_req = 2'b11;
      sw_trigger();
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) chk_all("t6 pre", c, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0);
         if (c < 4) step();
      end
      #2;
      rstn = 1'b0;
      #1;
      chk_all("t6 async", 4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      step();
      rstn = 1'b1;
      for (int c = 0; c < 8; c++) begin
         chk_all("t6 post", c, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
         step();
      end
      idle_gap(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
